// File: rtl/cc_miss_req_unit_pkg.sv
// Shared constants and types for the cache miss-request path: AXI burst shape,
// cache address-field positions and the miss-request FSM state encoding.
package cc_pkg;

    localparam logic [1:0]  AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0]  AXI_SIZE_8B    = 3'd3;
    localparam int unsigned LINE_BEATS     = 8;
    localparam logic [3:0]  AXI_LEN_LINE   = 4'(LINE_BEATS - 1);

    // Fields the fill stage extracts from the full miss address.
    localparam int unsigned OFFSET_LSB = 3;
    localparam int unsigned OFFSET_MSB = 5;
    localparam int unsigned INDEX_LSB  = 6;
    localparam int unsigned INDEX_MSB  = 14;
    localparam int unsigned TAG_LSB    = 15;
    localparam int unsigned TAG_MSB    = 31;

    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_e;

endpackage

// File: rtl/cc_miss_req_unit_if.sv
// Bundle of the miss-request, miss-address FIFO, AXI AR and AXI R monitor signals.
// master = the miss-request unit, slave = hit/miss logic, FIFO and memory side.
interface cc_miss_req_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              miss_req_valid_i;
    logic [ADDR_W-1:0] miss_req_addr_i;
    logic              miss_req_ready_o;

    logic              miss_addr_fifo_full_i;
    logic              miss_addr_fifo_wren_o;
    logic [ADDR_W-1:0] miss_addr_fifo_wdata_o;

    logic              mem_arvalid_o;
    logic              mem_arready_i;
    logic [ADDR_W-1:0] mem_araddr_o;
    logic [3:0]        mem_arlen_o;
    logic [2:0]        mem_arsize_o;
    logic [1:0]        mem_arburst_o;

    logic              mem_rvalid_i;
    logic              mem_rready_i;
    logic              mem_rlast_i;

    modport master (
        input  miss_req_valid_i, miss_req_addr_i,
        output miss_req_ready_o,
        input  miss_addr_fifo_full_i,
        output miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
        output mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
        input  mem_arready_i,
        input  mem_rvalid_i, mem_rready_i, mem_rlast_i
    );

    modport slave (
        output miss_req_valid_i, miss_req_addr_i,
        input  miss_req_ready_o,
        output miss_addr_fifo_full_i,
        input  miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
        input  mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
        output mem_arready_i,
        output mem_rvalid_i, mem_rready_i, mem_rlast_i
    );

endinterface

// File: rtl/cc_miss_req_unit_outstanding_cnt.sv
// Up/down count of AR bursts whose R burst has not yet finished, with the
// limit compare that gates new miss acceptance.
module cc_outstanding_cnt
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             below_max_o,
    output logic             nonzero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc_i, dec_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign below_max_o = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign nonzero_o   = (cnt_q != '0);

    // Increment past the limit or a burst end with nothing in flight is a protocol fault.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc_i && !dec_i && cnt_q >= CNT_W'(MAX_OUTSTANDING)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec_i && !inc_i && cnt_q == '0));

endmodule

// File: rtl/cc_miss_req_unit.sv
// Accepts one cache line miss at a time, pushes its address to the miss-address
// FIFO and issues the matching critical-word-first WRAP read burst.
module cc_miss_req_unit
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    cc_miss_req_unit_if.master bus,
    output logic               busy_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wren_q,  wren_d;

    logic             accept;
    logic             burst_done;
    logic             below_max;
    logic             nonzero;
    logic [CNT_W-1:0] outstanding;

    always_comb begin
        bus.miss_req_ready_o = rst_n && (state_q == S_IDLE) && below_max
                               && !bus.miss_addr_fifo_full_i;
        accept     = bus.miss_req_valid_i && bus.miss_req_ready_o;
        burst_done = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wren_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    addr_d  = bus.miss_req_addr_i;
                    wren_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.mem_arready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
        end
    end

    // Counting at accept time makes the new burst visible in the same cycle AR rises.
    cc_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (accept),
        .dec_i       (burst_done),
        .cnt_o       (outstanding),
        .below_max_o (below_max),
        .nonzero_o   (nonzero)
    );

    always_comb begin
        bus.miss_addr_fifo_wren_o  = wren_q;
        bus.miss_addr_fifo_wdata_o = addr_q;
        bus.mem_arvalid_o          = (state_q == S_ISSUE);
        bus.mem_araddr_o           = {addr_q[ADDR_W-1:OFFSET_LSB], {OFFSET_LSB{1'b0}}};
        bus.mem_arlen_o            = AXI_LEN_LINE;
        bus.mem_arsize_o           = AXI_SIZE_8B;
        bus.mem_arburst_o          = AXI_BURST_WRAP;
        busy_o                     = (state_q != S_IDLE) || nonzero;
    end

endmodule

// File: doc/cc_miss_req_unit.md
Name: cc_miss_req_unit

Overview:
Upstream neighbour of the cache data-fill stage. Accepts one line-miss request at a time from the cache hit/miss logic and records the miss address in the miss-address FIFO that the fill stage pops. It then issues the matching AXI read-address (AR) burst to memory: WRAP burst, critical word first. It also tracks outstanding line fills, so the fill stage always finds a FIFO entry for every R burst it sees.

Parameters:
MAX_OUTSTANDING, 2, maximum AR bursts issued whose R burst has not yet completed (RLAST handshake); legal range 1..7
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
miss_req_valid_i  in  1  miss request valid
miss_req_addr_i  in  32  byte address of missing word
miss_req_ready_o  out  1  request accepted when valid&ready
miss_addr_fifo_full_i  in  1  miss-address FIFO full
miss_addr_fifo_wren_o  out  1  FIFO push strobe
miss_addr_fifo_wdata_o  out  32  pushed address (unmodified miss_req_addr_i)
mem_arvalid_o  out  1  AXI AR valid
mem_arready_i  in  1  AXI AR ready
mem_araddr_o  out  32  AXI AR address
mem_arlen_o  out  4  AXI AR burst length (beats-1)
mem_arsize_o  out  3  AXI AR beat size
mem_arburst_o  out  2  AXI AR burst type
mem_rvalid_i  in  1  AXI R valid (monitor only)
mem_rready_i  in  1  AXI R ready (monitor only)
mem_rlast_i  in  1  AXI R last (monitor only)
busy_o  out  1  state!=IDLE or outstanding!=0

Behaviour:
- Reset values:
  - all outputs 0 except constant AR fields
  - state IDLE; outstanding counter 0; address register 0
- Constant AR fields:
  - mem_arlen_o=4'd7 (8 beats)
  - mem_arsize_o=3'd3 (8 bytes)
  - mem_arburst_o=2'b10 (WRAP)
- States:
  - IDLE: wait for a request.
  - ISSUE: hold AR valid until handshake.
- miss_req_ready_o (combinational):
  - ready = (state==IDLE) & (outstanding<MAX_OUTSTANDING) & !miss_addr_fifo_full_i
  - forced 0 while rst_n=0
- Accept at cycle T (valid&ready):
  - latch address
  - at T+1: miss_addr_fifo_wren_o=1 for exactly one cycle, wdata=latched address
  - at T+1: mem_arvalid_o=1, mem_araddr_o={addr[31:3],3'b000}
  - outstanding += 1 at T+1
  - state -> ISSUE
- ISSUE:
  - mem_arvalid_o and mem_araddr_o held stable until mem_arvalid_o&mem_arready_i
  - cycle after handshake: arvalid=0, state -> IDLE
  - arready high in the first ISSUE cycle gives a 1-cycle AR
  - no combinational path arready->arvalid
- Throughput: at most one accept per 2 cycles (accept, AR handshake, IDLE-accept).
- Ordering:
  - FIFO push is never later than AR assertion, so FIFO order equals AR order.
  - Single AXI ID; memory returns bursts in order.
- Outstanding counter:
  - width 3
  - -1 on mem_rvalid_i&mem_rready_i&mem_rlast_i
  - simultaneous +1/-1 leaves it unchanged
  - saturation/underflow is an error, covered by assertions; never wraps
- FIFO full:
  - blocks acceptance only
  - FIFO becoming full during ISSUE does not affect the pending AR (entry already pushed)
- Duplicate misses to an in-flight line are not merged; upstream stalls its pipeline on a miss.
- Reset mid-operation (rst_n=0 in any state):
  - next cycle state IDLE, arvalid=0, counter 0
  - no FIFO push
  - memory side is reset together.
- Address bits [2:0] are dropped on AR only; the FIFO keeps full address so the fill stage derives index [14:6], tag [31:15] and start offset [5:3].

Decomposition:
- Package cc_pkg holds:
  - AXI constants: AXI_BURST_WRAP=2'b10, AXI_SIZE_8B=3'd3, LINE_BEATS=8
  - address-field slice constants: OFFSET [5:3], INDEX [14:6], TAG [31:15]
  - state enum typedef {S_IDLE,S_ISSUE}
- One small sub-module: cc_outstanding_cnt (up/down counter with limit compare, simultaneous inc/dec, overflow/underflow assertions); everything else stays in the top.

Test Plan:
- Single miss, addr 0x0001_2358, arready immediate:
  - T+1: wren=1, wdata=0x0001_2358, araddr=0x0001_2358, arvalid=1
  - T+2: arvalid=0, outstanding=1
  - after 8 R beats with rlast: outstanding=0, busy=0
- arready delayed 5 cycles: araddr/arvalid stable all 5 cycles; exactly one wren pulse.
- MAX_OUTSTANDING=2:
  - three back-to-back misses: third held (ready=0) until first RLAST handshake
  - it is accepted the cycle after; AR order equals FIFO push order
- miss_addr_fifo_full_i=1 with valid=1 for 10 cycles: no accept, no wren, no arvalid; deassert full -> accept next cycle.
- RLAST handshake in the same cycle as the counter increment (outstanding=1): counter stays 1.
- rst_n=0 in ISSUE with arvalid=1: next cycle arvalid=0, wren=0, outstanding=0, ready=0 while reset held, ready=1 one cycle after release.
